video_stream_arbiter: RTL and testbench

Frame-aligned 2:1 arbiter for the AXI4-Stream video path. It shares the single downstream video stream, feeding the pixel unpacker and the VDMA/video-out chain, between two upstream sources, e.g. the framebuffer reader and a capture or overlay stream. Source switching happens only on frame boundaries, counted in lines, so the display never sees a torn frame. The output is registered through a skid buffer for full throughput.

---
 rtl/video_stream_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_video_stream_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_arbiter.sv
// ---------------------------------------------------------------------------
// video_stream_arbiter
//
// Frame-aligned 2:1 arbiter for an AXI4-Stream video path. One of two
// upstream sources owns the downstream stream. Ownership can change only
// between frames. A frame is counted in lines: it starts with a tuser beat
// and ends after vsize tlast beats. The output is registered through a
// main register plus a one-entry skid register, so the block sustains one
// beat per cycle and its ready is a registered signal.
//
// Parameters:
//   DATA_W      tdata width of all streams
//   LINE_CNT_W  width of the line counter and of vsize
//
// Ports:
//   vid_aclk, vid_aresetn     clock and asynchronous active-low reset
//   sel_req                   requested source; sampled only between frames
//   vsize                     lines per frame (0 behaves as 1)
//   active_src                source that currently owns the output
//   frame_done                one-cycle pulse after the last line is accepted
//   src0_axis_vid_*           source 0 stream (tdata/tvalid/tuser/tlast/tready)
//   src1_axis_vid_*           source 1 stream (tdata/tvalid/tuser/tlast/tready)
//   out_axis_vid_*            arbitrated output stream
//
// Build option:
//   VIDEO_ARB_FLUSH_EN  when defined, the non-active source sees tready=1 and
//                       its beats are discarded. When undefined, it sees
//                       tready=0 and is held.
// ---------------------------------------------------------------------------
module video_stream_arbiter #(
  parameter int DATA_W     = 32,
  parameter int LINE_CNT_W = 12
) (
  input  logic                  vid_aclk,
  input  logic                  vid_aresetn,
  input  logic                  sel_req,
  input  logic [LINE_CNT_W-1:0] vsize,
  output logic                  active_src,
  output logic                  frame_done,
  input  logic [DATA_W-1:0]     src0_axis_vid_tdata,
  input  logic                  src0_axis_vid_tvalid,
  input  logic                  src0_axis_vid_tuser,
  input  logic                  src0_axis_vid_tlast,
  output logic                  src0_axis_vid_tready,
  input  logic [DATA_W-1:0]     src1_axis_vid_tdata,
  input  logic                  src1_axis_vid_tvalid,
  input  logic                  src1_axis_vid_tuser,
  input  logic                  src1_axis_vid_tlast,
  output logic                  src1_axis_vid_tready,
  output logic [DATA_W-1:0]     out_axis_vid_tdata,
  output logic                  out_axis_vid_tuser,
  output logic                  out_axis_vid_tlast,
  output logic                  out_axis_vid_tvalid,
  input  logic                  out_axis_vid_tready
);

`ifdef VIDEO_ARB_FLUSH_EN
  localparam logic IDLE_SRC_READY = 1'b1;
`else
  localparam logic IDLE_SRC_READY = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  active_src_q, active_src_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic                  frame_done_q, frame_done_d;

  logic                  main_valid_q, main_valid_d;
  logic [DATA_W-1:0]     main_data_q, main_data_d;
  logic                  main_user_q, main_user_d;
  logic                  main_last_q, main_last_d;

  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]     skid_data_q, skid_data_d;
  logic                  skid_user_q, skid_user_d;
  logic                  skid_last_q, skid_last_d;

  logic                  src0_ready_q, src0_ready_d;
  logic                  src1_ready_q, src1_ready_d;

  // Active-source view and frame-control helpers
  logic                  in_valid_s;
  logic                  in_ready_s;
  logic [DATA_W-1:0]     in_data_s;
  logic                  in_user_s;
  logic                  in_last_s;
  logic                  accept_s;
  logic                  fwd_s;
  logic                  main_free_s;
  logic [LINE_CNT_W-1:0] last_line_s;
  logic [LINE_CNT_W-1:0] cnt_base_s;

  // Next-state logic: frame tracking, source ownership, skid buffer and readies
  always_comb begin
    in_valid_s  = active_src_q ? src1_axis_vid_tvalid : src0_axis_vid_tvalid;
    in_ready_s  = active_src_q ? src1_ready_q         : src0_ready_q;
    in_data_s   = active_src_q ? src1_axis_vid_tdata  : src0_axis_vid_tdata;
    in_user_s   = active_src_q ? src1_axis_vid_tuser  : src0_axis_vid_tuser;
    in_last_s   = active_src_q ? src1_axis_vid_tlast  : src0_axis_vid_tlast;
    accept_s    = in_valid_s & in_ready_s;

    // vsize of 0 behaves like 1, so the last line index is 0 in both cases
    if (vsize == {LINE_CNT_W{1'b0}}) begin
      last_line_s = {LINE_CNT_W{1'b0}};
    end else begin
      last_line_s = vsize - {{(LINE_CNT_W-1){1'b0}}, 1'b1};
    end

    // A tuser beat (SOF or mid-frame resync) restarts the line count
    cnt_base_s   = in_user_s ? {LINE_CNT_W{1'b0}} : line_cnt_q;

    state_d      = state_q;
    active_src_d = active_src_q;
    line_cnt_d   = line_cnt_q;
    frame_done_d = 1'b0;
    fwd_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Pre-SOF beats are dropped. On the SOF beat the owner freezes with
        // the source that delivered it, not a newly requested one.
        if (accept_s && in_user_s) begin
          fwd_s        = 1'b1;
          active_src_d = active_src_q;
        end else begin
          fwd_s        = 1'b0;
          active_src_d = sel_req;
        end
      end
      ST_PASS: begin
        fwd_s = accept_s;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fwd_s) begin
      if (in_last_s) begin
        if (cnt_base_s == last_line_s) begin
          frame_done_d = 1'b1;
          line_cnt_d   = {LINE_CNT_W{1'b0}};
          state_d      = ST_IDLE;
        end else begin
          line_cnt_d   = cnt_base_s + {{(LINE_CNT_W-1){1'b0}}, 1'b1};
          state_d      = ST_PASS;
        end
      end else begin
        line_cnt_d = cnt_base_s;
        state_d    = ST_PASS;
      end
    end else begin
      line_cnt_d = line_cnt_d;
    end

    // Skid buffer: the main register drives the output. The skid register
    // catches the one beat accepted while the main register is stalled.
    main_free_s  = ~main_valid_q | out_axis_vid_tready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_user_d  = main_user_q;
    main_last_d  = main_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_user_d  = skid_user_q;
    skid_last_d  = skid_last_q;

    if (main_free_s) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_user_d  = skid_user_q;
        main_last_d  = skid_last_q;
        skid_valid_d = fwd_s;
        if (fwd_s) begin
          skid_data_d = in_data_s;
          skid_user_d = in_user_s;
          skid_last_d = in_last_s;
        end else begin
          skid_data_d = skid_data_q;
        end
      end else begin
        main_valid_d = fwd_s;
        if (fwd_s) begin
          main_data_d = in_data_s;
          main_user_d = in_user_s;
          main_last_d = in_last_s;
        end else begin
          main_data_d = main_data_q;
        end
      end
    end else begin
      if (fwd_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_s;
        skid_user_d  = in_user_s;
        skid_last_d  = in_last_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end

    // Readies are registered. The next owner is ready while the skid is empty.
    if (active_src_d) begin
      src0_ready_d = IDLE_SRC_READY;
      src1_ready_d = ~skid_valid_d;
    end else begin
      src0_ready_d = ~skid_valid_d;
      src1_ready_d = IDLE_SRC_READY;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
    if (!vid_aresetn) begin
      state_q      <= ST_IDLE;
      active_src_q <= 1'b0;
      line_cnt_q   <= {LINE_CNT_W{1'b0}};
      frame_done_q <= 1'b0;
      main_valid_q <= 1'b0;
      main_data_q  <= {DATA_W{1'b0}};
      main_user_q  <= 1'b0;
      main_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= {DATA_W{1'b0}};
      skid_user_q  <= 1'b0;
      skid_last_q  <= 1'b0;
      src0_ready_q <= 1'b0;
      src1_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      line_cnt_q   <= line_cnt_d;
      frame_done_q <= frame_done_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_user_q  <= main_user_d;
      main_last_q  <= main_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_user_q  <= skid_user_d;
      skid_last_q  <= skid_last_d;
      src0_ready_q <= src0_ready_d;
      src1_ready_q <= src1_ready_d;
    end
  end

  assign active_src           = active_src_q;
  assign frame_done           = frame_done_q;
  assign src0_axis_vid_tready = src0_ready_q;
  assign src1_axis_vid_tready = src1_ready_q;
  assign out_axis_vid_tvalid  = main_valid_q;
  assign out_axis_vid_tdata   = main_data_q;
  assign out_axis_vid_tuser   = main_user_q;
  assign out_axis_vid_tlast   = main_last_q;

endmodule

// File: tb/tb_video_stream_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for video_stream_arbiter. Expected values are written
// out by hand. Checks are immediate assertions.
// ---------------------------------------------------------------------------
module tb_video_stream_arbiter;

`ifdef VIDEO_ARB_FLUSH_EN
  localparam logic FLUSH_EXP = 1'b1;
`else
  localparam logic FLUSH_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sel_req;
  logic [11:0] vsize;
  logic        active_src;
  logic        frame_done;
  logic [31:0] s0_data, s1_data;
  logic        s0_valid, s0_user, s0_last, s0_ready;
  logic        s1_valid, s1_user, s1_last, s1_ready;
  logic [31:0] o_data;
  logic        o_user, o_last, o_valid, o_ready;
  logic        o_ready_dir, rand_en, rand_bit;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];
  int    fd_cnt;
  int    cyc;
  int    n_assert;
  int    n_fail;
  int    t0;

  assign o_ready = rand_en ? rand_bit : o_ready_dir;

  video_stream_arbiter #(.DATA_W(32), .LINE_CNT_W(12)) dut (
    .vid_aclk             (clk),
    .vid_aresetn          (rst_n),
    .sel_req              (sel_req),
    .vsize                (vsize),
    .active_src           (active_src),
    .frame_done           (frame_done),
    .src0_axis_vid_tdata  (s0_data),
    .src0_axis_vid_tvalid (s0_valid),
    .src0_axis_vid_tuser  (s0_user),
    .src0_axis_vid_tlast  (s0_last),
    .src0_axis_vid_tready (s0_ready),
    .src1_axis_vid_tdata  (s1_data),
    .src1_axis_vid_tvalid (s1_valid),
    .src1_axis_vid_tuser  (s1_user),
    .src1_axis_vid_tlast  (s1_last),
    .src1_axis_vid_tready (s1_ready),
    .out_axis_vid_tdata   (o_data),
    .out_axis_vid_tuser   (o_user),
    .out_axis_vid_tlast   (o_last),
    .out_axis_vid_tvalid  (o_valid),
    .out_axis_vid_tready  (o_ready)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random downstream ready, changed away from the active edge
  initial begin
    rand_bit = 1'b1;
    forever begin
      @(negedge clk);
      rand_bit = 1'($urandom_range(0, 1));
    end
  end

  // Output observer: records every delivered beat and frame_done pulses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && o_valid && o_ready) q.push_back({o_user, o_last, o_data});
    if (rst_n && frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat on a source and hold it until accepted (bounded wait)
  task automatic send(input int src, input logic [31:0] d, input logic u, input logic l);
    logic rdy;
    int   n;
    if (src == 1) begin
      s1_valid = 1'b1; s1_data = d; s1_user = u; s1_last = l;
    end else begin
      s0_valid = 1'b1; s0_data = d; s0_user = u; s0_last = l;
    end
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (src == 1) ? s1_ready : s0_ready;
      @(posedge clk);
      n++;
    end
    #1;
    if (src == 1) s1_valid = 1'b0;
    else          s0_valid = 1'b0;
    if (!rdy) check("send_timeout", 64'(rdy), 64'(1'b1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; fd_cnt = 0; cyc = 0;
    rst_n = 1'b0; sel_req = 1'b0; vsize = 12'd2;
    s0_valid = 1'b0; s0_data = 32'd0; s0_user = 1'b0; s0_last = 1'b0;
    s1_valid = 1'b0; s1_data = 32'd0; s1_user = 1'b0; s1_last = 1'b0;
    o_ready_dir = 1'b1; rand_en = 1'b0;

    // Reset values
    idle(3);
    check("rst_out_valid", 64'(o_valid), 64'(1'b0));
    check("rst_out_data", 64'({o_user, o_last, o_data}), 64'd0);
    check("rst_s0_ready", 64'(s0_ready), 64'(1'b0));
    check("rst_s1_ready", 64'(s1_ready), 64'(1'b0));
    check("rst_active_src", 64'(active_src), 64'(1'b0));
    check("rst_frame_done", 64'(frame_done), 64'(1'b0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s0_ready", 64'(s0_ready), 64'(1'b1));
    check("post_rst_s1_ready", 64'(s1_ready), 64'(FLUSH_EXP));

    // Pre-SOF line dropped, then one 2-line frame
    for (int i = 0; i < 4; i++) send(0, 32'hA0 + 32'(i), 1'b0, i == 3);
    check("presof_dropped", 64'(o_valid), 64'(1'b0));
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(0, 32'(i), i == 0, (i == 3) || (i == 7));
      if (i == 0) check("latency_beat0", 64'({o_valid, o_user, o_data}), {31'd0, 1'b1, 1'b1, 32'd0});
      if (i == 3) check("fd_not_line0", 64'(frame_done), 64'(1'b0));
    end
    check("throughput_8", 64'(cyc - t0), 64'd8);
    check("fd_pulse", 64'(frame_done), 64'(1'b1));
    idle(1);
    check("fd_one_cycle", 64'(frame_done), 64'(1'b0));
    idle(3);
    check("t1_count", 64'(q.size()), 64'd8);
    for (int i = 0; i < 8 && i < q.size(); i++)
      check($sformatf("t1_beat%0d", i), 64'(q[i]), 64'({i == 0, (i == 3) || (i == 7), 32'(i)}));
    check("t1_fd_cnt", 64'(fd_cnt), 64'd1);

    // sel_req toggled mid-frame; src1 holds a SOF beat meanwhile
    q.delete(); fd_cnt = 0;
    s1_valid = 1'b1; s1_data = 32'h100; s1_user = 1'b1; s1_last = 1'b0;
    send(0, 32'h10, 1'b1, 1'b0);
    send(0, 32'h11, 1'b0, 1'b0);
    sel_req = 1'b1;
    send(0, 32'h12, 1'b0, 1'b0);
    check("frozen_src", 64'(active_src), 64'(1'b0));
    check("nonactive_s1_ready", 64'(s1_ready), 64'(FLUSH_EXP));
    for (int i = 3; i < 8; i++) send(0, 32'h10 + 32'(i), 1'b0, (i == 3) || (i == 7));
    check("t2_fd", 64'({frame_done, active_src}), 64'({1'b1, 1'b0}));
    idle(1);
    check("switch_after_fd", 64'({active_src, s1_ready}), 64'({1'b1, 1'b1}));
    idle(1);
    s1_valid = 1'b0;
    check("src1_sof_out", 64'({o_valid, o_user, o_data}), {31'd0, 1'b1, 1'b1, 32'h100});
    sel_req = 1'b0;
    for (int i = 1; i < 8; i++) send(1, 32'h100 + 32'(i), 1'b0, (i == 3) || (i == 7));
    check("t2_src1_fd", 64'(frame_done), 64'(1'b1));
    idle(3);
    check("t2_count", 64'(q.size()), 64'd16);
    for (int i = 0; i < 8 && i < q.size(); i++)
      check($sformatf("t2_src0_beat%0d", i), 64'(q[i].data), 64'(32'h10 + 32'(i)));
    if (q.size() > 8) check("t2_next_beat", 64'({q[8].user, q[8].data}), 64'({1'b1, 32'h100}));
    check("t2_back_to_src0", 64'(active_src), 64'(1'b0));
    check("t2_fd_cnt", 64'(fd_cnt), 64'd2);

    // Random backpressure over a 3-line x 16-beat frame
    q.delete(); fd_cnt = 0; vsize = 12'd3; rand_en = 1'b1;
    for (int i = 0; i < 48; i++) send(0, 32'(i), i == 0, (i % 16) == 15);
    rand_en = 1'b0;
    idle(6);
    check("t3_count", 64'(q.size()), 64'd48);
    for (int i = 0; i < 48 && i < q.size(); i++)
      check($sformatf("t3_beat%0d", i), 64'(q[i]), 64'({i == 0, (i % 16) == 15, 32'(i)}));
    check("t3_fd_cnt", 64'(fd_cnt), 64'd1);

    // Mid-frame resync at line 1 beat 2 with vsize=3
    q.delete(); fd_cnt = 0;
    for (int i = 0; i < 4; i++) send(0, 32'h200 + 32'(i), i == 0, i == 3);
    for (int i = 0; i < 4; i++) send(0, 32'h210 + 32'(i), i == 2, i == 3);
    check("resync_line_a", 64'(frame_done), 64'(1'b0));
    for (int i = 0; i < 4; i++) send(0, 32'h220 + 32'(i), 1'b0, i == 3);
    check("resync_line_b", 64'(frame_done), 64'(1'b0));
    for (int i = 0; i < 4; i++) send(0, 32'h230 + 32'(i), 1'b0, i == 3);
    check("resync_line_c_fd", 64'(frame_done), 64'(1'b1));
    idle(3);
    check("t4_count", 64'(q.size()), 64'd16);
    if (q.size() > 6) check("t4_resync_beat", 64'({q[6].user, q[6].data}), 64'({1'b1, 32'h212}));
    check("t4_fd_cnt", 64'(fd_cnt), 64'd1);

    // Reset with the skid full
    vsize = 12'd2; o_ready_dir = 1'b0;
    send(0, 32'h300, 1'b1, 1'b0);
    send(0, 32'h301, 1'b0, 1'b0);
    check("skid_full_ready", 64'({s0_ready, o_valid, o_data}), {30'd0, 1'b0, 1'b1, 32'h300});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 64'({o_valid, s0_ready, s1_ready}), 64'd0);
    sel_req = 1'b1;
    @(negedge clk); rst_n = 1'b1; o_ready_dir = 1'b1;
    @(posedge clk); #1;
    check("post_rst2_src", 64'({active_src, o_valid, s1_ready, s0_ready}), 64'({1'b1, 1'b0, 1'b1, FLUSH_EXP}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
